// File: rtl/acq_pkg.sv
// Shared types and constants for the serial-search acquisition sequencer.
package acq_pkg;

    localparam int ACC_W        = 37;
    localparam int CODE_PERIOD  = 2046;
    localparam int SETTLE_DUMPS = 2;

    localparam logic [28:0] CARR_FC_BASE = 29'h10000000;
    localparam logic [27:0] CODE_FC      = 28'h4000000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        SETTLE,
        ACCUM,
        EVAL,
        SLEW,
        DONE
    } state_t;

endpackage

// File: rtl/acq_power_acc.sv
// Two-stage non-coherent power path: registered I^2+Q^2, then saturating accumulate.
module acq_power_acc
    import acq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               dump_valid,
    input  logic signed [15:0] i_prompt,
    input  logic signed [15:0] q_prompt,
    output logic [ACC_W-1:0]   acc,
    output logic               acc_upd
);

    logic signed [31:0] ii;
    logic signed [31:0] qq;
    logic [32:0]        p_d;
    logic [32:0]        p_q;
    logic               p_vld;
    logic [ACC_W:0]     sum;

    assign ii  = 32'(i_prompt) * 32'(i_prompt);
    assign qq  = 32'(q_prompt) * 32'(q_prompt);
    assign p_d = {1'b0, ii} + {1'b0, qq};
    assign sum = {1'b0, acc} + {{(ACC_W - 32){1'b0}}, p_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            p_vld   <= 1'b0;
            acc     <= '0;
            acc_upd <= 1'b0;
        end else if (clear) begin
            p_vld   <= 1'b0;
            acc     <= '0;
            acc_upd <= 1'b0;
        end else begin
            p_vld   <= dump_valid;
            acc_upd <= p_vld;
            if (dump_valid)
                p_q <= p_d;
            // Clamp at all-ones instead of wrapping on overflow.
            if (p_vld)
                acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/acq_search_ctrl.sv
// Serial Doppler/code-phase search sequencer driving one tracking channel's
// carrier NCO, PRN key load and code slew, with best-cell reporting.
module acq_search_ctrl
    import acq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [9:0]         prn_key_in,
    input  logic [23:0]        dop_start,
    input  logic [15:0]        dop_step,
    input  logic [5:0]         num_bins,
    input  logic [3:0]         code_step,
    input  logic [4:0]         noncoh,
    input  logic [ACC_W-1:0]   threshold,
    input  logic               dump,
    input  logic signed [15:0] i_prompt,
    input  logic signed [15:0] q_prompt,
    output logic [28:0]        carr_nco_fc,
    output logic [27:0]        code_nco_fc,
    output logic [9:0]         prn_key,
    output logic               prn_key_enable,
    output logic [10:0]        code_slew,
    output logic               slew_enable,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [5:0]         best_bin,
    output logic [10:0]        best_code,
    output logic [ACC_W-1:0]   best_power
);

    state_t state;
    state_t state_d;

    logic [15:0]      dop_step_r;
    logic [5:0]       nb_r;
    logic [3:0]       step_r;
    logic [4:0]       nc_r;
    logic [ACC_W-1:0] thr_r;

    logic [5:0]       bin;
    logic [10:0]      code_pos;
    logic [1:0]       settle_cnt;
    logic [4:0]       n_cnt;

    logic [ACC_W-1:0] acc;
    logic             acc_upd;
    logic             dump_acc;
    logic             acc_clear;

    logic [11:0]      next_pos;
    logic             last_cell;
    logic             last_bin;
    logic             settle_last;
    logic             accum_last;
    logic             hit;
    logic [10:0]      slew_amt;
    logic             in_slew;

    assign code_nco_fc = CODE_FC;

    assign next_pos    = {1'b0, code_pos} + {8'd0, step_r};
    assign last_cell   = next_pos >= 12'(CODE_PERIOD);
    assign last_bin    = bin == nb_r - 6'd1;
    assign settle_last = dump && settle_cnt == 2'(SETTLE_DUMPS - 1);
    assign accum_last  = acc_upd && n_cnt == nc_r - 5'd1;
    assign hit         = acc >= thr_r;

    // The bin-closing slew returns the channel to the bin's starting phase.
    assign slew_amt = last_cell ? 11'(CODE_PERIOD) - code_pos
                                : {7'd0, step_r};

    assign dump_acc  = dump && state == ACCUM && !abort;
    assign acc_clear = state == SETTLE && settle_last && !abort;

    acq_power_acc u_power (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear),
        .dump_valid (dump_acc),
        .i_prompt   (i_prompt),
        .q_prompt   (q_prompt),
        .acc        (acc),
        .acc_upd    (acc_upd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:     if (start) state_d = LOAD_KEY;
            LOAD_KEY: state_d = SETTLE;
            SETTLE:   if (settle_last) state_d = ACCUM;
            ACCUM:    if (accum_last) state_d = EVAL;
            EVAL: begin
                if (hit || (last_cell && last_bin))
                    state_d = DONE;
                else
                    state_d = SLEW;
            end
            SLEW:     state_d = SETTLE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (abort)
            state_d = IDLE;
    end

    always_comb begin
        in_slew        = state == SLEW && !abort;
        busy           = state != IDLE && state != DONE && !abort;
        done           = state == DONE && !abort;
        prn_key_enable = state == LOAD_KEY && !abort;
        slew_enable    = in_slew && slew_amt != 11'd0;
        code_slew      = in_slew ? slew_amt : 11'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dop_step_r  <= '0;
            nb_r        <= 6'd1;
            step_r      <= 4'd1;
            nc_r        <= 5'd1;
            thr_r       <= '0;
            bin         <= '0;
            code_pos    <= '0;
            settle_cnt  <= '0;
            n_cnt       <= '0;
            carr_nco_fc <= CARR_FC_BASE;
            prn_key     <= '0;
            found       <= 1'b0;
            best_bin    <= '0;
            best_code   <= '0;
            best_power  <= '0;
        end else if (!abort) begin
            unique case (state)
                IDLE: if (start) begin
                    dop_step_r  <= dop_step;
                    nb_r        <= (num_bins == 6'd0) ? 6'd1 : num_bins;
                    step_r      <= (code_step == 4'd0) ? 4'd1 : code_step;
                    nc_r        <= (noncoh == 5'd0) ? 5'd1 :
                                   (noncoh > 5'd16) ? 5'd16 : noncoh;
                    thr_r       <= threshold;
                    prn_key     <= prn_key_in;
                    bin         <= '0;
                    code_pos    <= '0;
                    found       <= 1'b0;
                    best_bin    <= '0;
                    best_code   <= '0;
                    best_power  <= '0;
                    carr_nco_fc <= CARR_FC_BASE
                                 + {{5{dop_start[23]}}, dop_start};
                end
                LOAD_KEY: settle_cnt <= '0;
                SETTLE: begin
                    if (dump)
                        settle_cnt <= settle_cnt + 2'd1;
                    if (settle_last)
                        n_cnt <= '0;
                end
                ACCUM: if (acc_upd) n_cnt <= n_cnt + 5'd1;
                EVAL: begin
                    // Strict compare: ties keep the earlier cell.
                    if (acc > best_power) begin
                        best_power <= acc;
                        best_bin   <= bin;
                        best_code  <= code_pos;
                    end
                    if (hit)
                        found <= 1'b1;
                end
                SLEW: begin
                    settle_cnt <= '0;
                    if (last_cell) begin
                        code_pos    <= '0;
                        bin         <= bin + 6'd1;
                        carr_nco_fc <= carr_nco_fc + 29'(dop_step_r);
                    end else begin
                        code_pos <= next_pos[10:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
